// File: rtl/ahb_stream_pkg.sv
// ahb_stream_pkg: HTRANS encodings, register map, bit indices and FSM states shared by ahb_stream_slave.
package ahb_stream_pkg;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_OVF_CLR = 2'd3;
    localparam int CTRL_EN        = 0;
    localparam int CTRL_FLUSH     = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_LEVEL_LSB = 16;
    typedef enum logic [2:0] {IDLE, DPHASE, WAIT_DATA, ERR1, ERR2} state_e;
endpackage

// File: rtl/ahb_stream_slave_fifo.sv
// sync_fifo: first-word-fall-through FIFO with flush; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full    = cnt_q == LW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign level   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a word when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    always_comb begin
        wr_d  = flush ? '0 : wr_q + AW'(do_push);
        rd_d  = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + LW'(do_push) - LW'(do_pop);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/ahb_stream_slave.sv
// ahb_stream_slave: AHB-lite slave buffering a non-stallable word stream behind CTRL/STATUS/DATA/OVF_CLR.
// AHB_STREAM_TIMEOUT_EN adds the empty-DATA wait timeout with a two-cycle ERROR response.
module ahb_stream_slave
    import ahb_stream_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ahb_haddr_i,
    input  logic        ahb_hwrite_i,
    input  logic [2:0]  ahb_hsize_i,
    input  logic [1:0]  ahb_htrans_i,
    input  logic [31:0] ahb_hwdata_i,
    output logic        ahb_hready_o,
    output logic        ahb_hresp_o,
    output logic [31:0] ahb_hrdata_o,
    input  logic        s_valid_i,
    input  logic [31:0] s_data_i,
    output logic        irq_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    state_e state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic write_q, write_d, hready_q, hready_d;
    logic enable_q, enable_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic [31:0] hrdata_q, hrdata_d, rd_word, fifo_rdata;
    logic pop, flush, ovf_clr, push, ovf_set, full, empty, accept;
    logic [LW-1:0] level;
    logic unused;
`ifdef AHB_STREAM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic hresp_q, hresp_d;
    assign ahb_hresp_o = hresp_q;
`else
    assign ahb_hresp_o = 1'b0;
`endif
    assign unused       = ^{ahb_haddr_i[31:4], ahb_haddr_i[1:0], ahb_hsize_i, ahb_hwdata_i[31:3], 16'(TIMEOUT)};
    assign ahb_hready_o = hready_q;
    assign ahb_hrdata_o = hrdata_q;
    assign irq_o        = irq_en_q & ~empty;
    assign accept       = (state_q == IDLE || state_q == DPHASE) &&
                          (ahb_htrans_i == HTRANS_NSEQ || ahb_htrans_i == HTRANS_SEQ);
    // flush wins over an arriving word, and the word it drops is not an overflow
    assign push    = s_valid_i & enable_q & ~flush;
    assign ovf_set = push & full & ~pop;
    assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .resetn(resetn), .push(push), .pop(pop), .flush(flush),
        .wdata(s_data_i), .rdata(fifo_rdata), .full(full), .empty(empty), .level(level)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        hready_d = hready_q;
        hrdata_d = hrdata_q;
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        pop      = 1'b0;
        flush    = 1'b0;
        ovf_clr  = 1'b0;
        rd_word  = '0;
`ifdef AHB_STREAM_TIMEOUT_EN
        hresp_d  = hresp_q;
        cnt_d    = cnt_q;
`endif
        if (state_q == DPHASE && write_q) begin
            if (addr_q == REG_CTRL) begin
                enable_d = ahb_hwdata_i[CTRL_EN];
                irq_en_d = ahb_hwdata_i[CTRL_IRQ_EN];
                flush    = ahb_hwdata_i[CTRL_FLUSH];
            end
            ovf_clr = addr_q == REG_OVF_CLR && ahb_hwdata_i[0];
        end
        case (ahb_haddr_i[3:2])
            REG_CTRL: begin
                rd_word[CTRL_EN]     = enable_q;
                rd_word[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_STATUS: begin
                rd_word[STAT_EMPTY]              = empty;
                rd_word[STAT_FULL]               = full;
                rd_word[STAT_OVF]                = ovf_q;
                rd_word[STAT_LEVEL_LSB +: 8]     = 8'(level);
            end
            REG_DATA: rd_word = fifo_rdata;
            default: ;
        endcase
        case (state_q)
            IDLE, DPHASE: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d   = ahb_haddr_i[3:2];
                    write_d  = ahb_hwrite_i;
                    hrdata_d = '0;
                    state_d  = DPHASE;
                    if (!ahb_hwrite_i && ahb_haddr_i[3:2] == REG_DATA && empty) begin
                        state_d  = WAIT_DATA;
                        hready_d = 1'b0;
`ifdef AHB_STREAM_TIMEOUT_EN
                        cnt_d    = 16'd1;
`endif
                    end else if (!ahb_hwrite_i) begin
                        hrdata_d = rd_word;
                        pop      = ahb_haddr_i[3:2] == REG_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (!empty) begin
                    pop      = 1'b1;
                    hrdata_d = fifo_rdata;
                    hready_d = 1'b1;
                    state_d  = IDLE;
                end
`ifdef AHB_STREAM_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT)) begin
                    state_d = ERR1;
                    hresp_d = 1'b1;
                end else cnt_d = cnt_q + 16'd1;
`endif
            end
`ifdef AHB_STREAM_TIMEOUT_EN
            ERR1: begin
                hready_d = 1'b1;
                hrdata_d = '0;
                state_d  = ERR2;
            end
            ERR2: begin
                hresp_d = 1'b0;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hrdata_q <= '0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hrdata_q <= hrdata_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
        end
    end
`ifdef AHB_STREAM_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            hresp_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hresp_q <= hresp_d;
        end
    end
`endif
endmodule
